mssd_param: RTL and testbench
=============================

# mssd_param

Parametrised serial stream demultiplexer. It receives framed messages on a single serial line, extracts a channel (port) number and a data word, checks parity and stop bit, then presents the word with a one-hot per-channel strobe. It succeeds the fixed 2-bit-port / 4-bit-data decoder. It adds configurable widths, optional parity, framing-error recovery and an error counter, and sits between the serial input pin and per-channel consumers.

## Interface
- PN_W, 2, port-number width; channel count NCH = 2**PN_W
- DATA_W, 4, data bits per frame
- PARITY_EN, 1, 1 = even-parity bit present after data; 0 = no parity bit
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- sin  in  1  serial input, idle high, sampled once per clk
- valid  out  1  one-cycle pulse: good frame decoded
- error  out  1  one-cycle pulse: parity or stop-bit failure
- pn  out  PN_W  port number of last good frame
- p  out  DATA_W  data of last good frame
- ch_valid  out  NCH  one-hot copy of valid at bit index pn
- busy  out  1  high while a frame is in progress (any state except IDLE/WAIT_HIGH)
- err_cnt  out  8  saturating count of error pulses

## Operation
- Frame, one bit per clk, MSB first: start(0), PN_W port bits, DATA_W data bits, [parity if PARITY_EN], stop(1). Frame length L = 2 + PN_W + DATA_W + PARITY_EN.
- Even parity: the XOR of all port bits, data bits and the parity bit must be 0.
- States: IDLE, PORT, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: sin=0 -> PORT with bit counter = 0. Otherwise stay.
- PORT: shift sin into the port shift register. After PN_W bits -> DATA.
- DATA: shift into the data shift register. After DATA_W bits -> PAR if PARITY_EN, else STOP.
- PAR: sample the parity bit into the running XOR. -> STOP.
- STOP, good frame (sin=1 and parity OK, or PARITY_EN=0): valid=1, ch_valid[pn]=1, pn/p load the shift registers. -> IDLE.
- STOP, parity failure with sin=1: error=1, err_cnt+1, pn/p hold. -> IDLE.
- STOP, sin=0 (framing error, regardless of parity): error=1, err_cnt+1, pn/p hold. -> WAIT_HIGH.
- WAIT_HIGH: stay until sin=1, then -> IDLE. A low line is never treated as a start bit here.
- err_cnt saturates at 8'hFF and never wraps.
- A single error pulse is produced per frame, even when parity and stop both fail.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, counters=0, valid=0, error=0, pn=0, p=0, ch_valid=0, busy=0, err_cnt=0. Reset takes effect on the edge only. A mid-frame reset aborts the frame with no valid/error pulse.
- All outputs are registered.
- Start bit sampled at edge e0; stop bit sampled at edge e0+L-1. valid/error/ch_valid are high for exactly the cycle after edge e0+L-1, and pn/p update at that same edge.
- busy rises after e0 and falls after e0+L-1.
- Back-to-back: a start bit at edge e0+L, the cycle right after the stop bit, is accepted. The minimum frame spacing is L cycles with no idle bit.
- Following a framing error, start detection resumes one edge after sin is first sampled high.
- Port and data bits are not qualified. Only the start, parity and stop bits are checked.

## Test plan
- Defaults; sin = 0,1,0,1,0,1,1,0,1 -> 9 cycles after start, valid=1 for one cycle, pn=2, p=4'hB, ch_valid=4'b0100, error=0, err_cnt=0.
- Same frame with parity bit=1 -> error=1 for one cycle, err_cnt=1, pn/p keep previous values (0/0 after reset), valid=0.
- Stop bit=0 with sin held low 3 more cycles, then 1, then a good frame (pn=1, p=4'h3, parity 1) -> one error pulse only, no false start while low, then valid with pn=1, p=4'h3.
- Two good frames back-to-back (pn=3, p=4'hF, parity 0; pn=0, p=4'h1, parity 1) -> valid pulses exactly 9 cycles apart, ch_valid 4'b1000 then 4'b0001.
- rst_n=0 for one edge after the 4th bit of a frame, then a complete good frame -> no pulse from the aborted frame, all outputs 0 after reset, second frame decoded.
- PARITY_EN=0, PN_W=3, DATA_W=8: frame 0, 101, 8'hA5, 1 -> valid after 13 cycles, pn=5, p=8'hA5, ch_valid=8'b0010_0000. Then 260 framing-error frames -> err_cnt holds at 8'hFF.

Source files
------------

// File: rtl/mssd_param.sv
// Serial stream demultiplexer: decodes start/port/data/[parity]/stop frames
// and presents each good word with a one-hot per-channel strobe.
module mssd_param #(
  parameter int PN_W      = 2,
  parameter int DATA_W    = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin,
  output logic                 valid,
  output logic                 error,
  output logic [PN_W-1:0]      pn,
  output logic [DATA_W-1:0]    p,
  output logic [(2**PN_W)-1:0] ch_valid,
  output logic                 busy,
  output logic [7:0]           err_cnt
);
  localparam int NCH   = 2**PN_W;
  localparam int CNT_W = $clog2(PN_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] PN_LAST   = CNT_W'(PN_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, PORT, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PN_W-1:0]   port_sr;
  logic [DATA_W-1:0] data_sr;
  logic              par_acc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Shift registers are always fully refilled before use, so they need no reset.
  always_ff @(posedge clk) begin
    case (state)
      PORT:    port_sr <= PN_W'({port_sr, sin});
      DATA:    data_sr <= DATA_W'({data_sr, sin});
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      par_acc  <= 1'b0;
      valid    <= 1'b0;
      error    <= 1'b0;
      pn       <= '0;
      p        <= '0;
      ch_valid <= '0;
      busy     <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      valid    <= 1'b0;
      error    <= 1'b0;
      ch_valid <= '0;
      case (state)
        IDLE: begin
          if (!sin) begin
            state   <= PORT;
            cnt     <= '0;
            par_acc <= 1'b0;
            busy    <= 1'b1;
          end
        end
        PORT: begin
          par_acc <= par_acc ^ sin;
          if (cnt == PN_LAST) begin
            state <= DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          par_acc <= par_acc ^ sin;
          if (cnt == DATA_LAST) begin
            state <= (PARITY_EN != 0) ? PAR : STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PAR: begin
          par_acc <= par_acc ^ sin;
          state   <= STOP;
        end
        STOP: begin
          busy <= 1'b0;
          // A framing error always wins, so at most one error pulse per frame.
          if (!sin) begin
            error   <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            state   <= WAIT_HIGH;
          end else if (PARITY_EN == 0 || !par_acc) begin
            valid    <= 1'b1;
            pn       <= port_sr;
            p        <= data_sr;
            ch_valid <= NCH'(1) << port_sr;
            state    <= IDLE;
          end else begin
            error   <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            state   <= IDLE;
          end
        end
        WAIT_HIGH: begin
          if (sin) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mssd_param.sv
// Bench for mssd_param: table-driven frames, hand corner sequences and
// randomized frames against a frame-level reference model.
module tb_mssd_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic       rst_na, sin_a, valid_a, error_a, busy_a;
  logic [1:0] pn_a;
  logic [3:0] p_a, chv_a;
  logic [7:0] cnt_a;

  // Wide configuration without parity
  logic       rst_nb, sin_b, valid_b, error_b, busy_b;
  logic [2:0] pn_b;
  logic [7:0] p_b, chv_b, cnt_b;

  mssd_param dut_a (
    .clk(clk), .rst_n(rst_na), .sin(sin_a), .valid(valid_a), .error(error_a),
    .pn(pn_a), .p(p_a), .ch_valid(chv_a), .busy(busy_a), .err_cnt(cnt_a)
  );

  mssd_param #(.PN_W(3), .DATA_W(8), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_nb), .sin(sin_b), .valid(valid_b), .error(error_b),
    .pn(pn_b), .p(p_b), .ch_valid(chv_b), .busy(busy_b), .err_cnt(cnt_b)
  );

  int passed = 0;
  int total  = 0;

  // Frame-level model state for instance A
  logic [1:0] m_pn;
  logic [3:0] m_p;
  int         m_cnt;

  typedef struct {
    logic [1:0] fpn;
    logic [3:0] fd;
    logic       fpar;
    logic       fstop;
    logic       ev;
    logic       ee;
    logic [1:0] epn;
    logic [3:0] ep;
    logic [7:0] ecnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic line_a(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) sin_a = v;
      @(posedge clk) #1;
      chk("line_valid", valid_a, 0);
      chk("line_error", error_a, 0);
      chk("line_busy", busy_a, 0);
    end
  endtask

  task automatic frame_a(input logic [1:0] fpn, input logic [3:0] fd, input logic fpar,
                         input logic fstop, input logic ev, input logic ee,
                         input logic [1:0] epn, input logic [3:0] ep, input logic [7:0] ecnt);
    logic [8:0] bits;
    logic [3:0] echv;
    bits = {1'b0, fpn, fd, fpar, fstop};
    for (int i = 8; i >= 0; i--) begin
      @(negedge clk) sin_a = bits[i];
      @(posedge clk) #1;
      if (i > 0) begin
        chk("mid_valid", valid_a, 0);
        chk("mid_error", error_a, 0);
        chk("mid_busy", busy_a, 1);
      end
    end
    echv = ev ? (4'b0001 << epn) : 4'b0000;
    chk("valid", valid_a, ev);
    chk("error", error_a, ee);
    chk("pn", pn_a, epn);
    chk("p", p_a, ep);
    chk("ch_valid", chv_a, echv);
    chk("err_cnt", cnt_a, ecnt);
    chk("end_busy", busy_a, 0);
  endtask

  // Reference: even parity over port+data+parity bits, stop must be 1.
  task automatic model_frame_a(input logic [1:0] fpn, input logic [3:0] fd,
                               input logic fpar, input logic fstop);
    bit good;
    good = fstop && ($countones({fpn, fd, fpar}) % 2 == 0);
    if (good) begin
      m_pn = fpn;
      m_p  = fd;
    end else if (m_cnt < 255) begin
      m_cnt = m_cnt + 1;
    end
    frame_a(fpn, fd, fpar, fstop, good, !good, m_pn, m_p, 8'(m_cnt));
    if (!fstop) begin
      line_a(1'b0, $urandom_range(0, 4));
      line_a(1'b1, $urandom_range(1, 2));
    end
  endtask

  task automatic frame_b(input logic [2:0] fpn, input logic [7:0] fd, input logic fstop,
                         input logic ev, input logic ee, input logic [2:0] epn,
                         input logic [7:0] ep, input logic [7:0] ecnt);
    logic [12:0] bits;
    logic [7:0]  echv;
    bits = {1'b0, fpn, fd, fstop};
    for (int i = 12; i >= 0; i--) begin
      @(negedge clk) sin_b = bits[i];
      @(posedge clk) #1;
    end
    echv = ev ? (8'b1 << epn) : 8'h00;
    chk("b_valid", valid_b, ev);
    chk("b_error", error_b, ee);
    chk("b_pn", pn_b, epn);
    chk("b_p", p_b, ep);
    chk("b_ch_valid", chv_b, echv);
    chk("b_err_cnt", cnt_b, ecnt);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'd2, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'h0, 8'd1};
    tbl[1] = '{2'd2, 4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'hB, 8'd1};
    tbl[2] = '{2'd3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4'hF, 8'd1};
    tbl[3] = '{2'd0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1, 8'd1};
    tbl[4] = '{2'd1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'h1, 8'd2};
    tbl[5] = '{2'd1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 8'd3};
    tbl[6] = '{2'd1, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h3, 8'd3};
    tbl[7] = '{2'd2, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'h3, 8'd4};
    tbl[8] = '{2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 8'd4};

    rst_na = 1'b0; rst_nb = 1'b0; sin_a = 1'b1; sin_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_a, 0);
    chk("rst_error", error_a, 0);
    chk("rst_pn", pn_a, 0);
    chk("rst_p", p_a, 0);
    chk("rst_chv", chv_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_b_cnt", cnt_b, 0);
    @(negedge clk) begin rst_na = 1'b1; rst_nb = 1'b1; end
    line_a(1'b1, 2);

    // Table: stop=1 frames run back-to-back; framing errors get low hold then high.
    foreach (tbl[k]) begin
      frame_a(tbl[k].fpn, tbl[k].fd, tbl[k].fpar, tbl[k].fstop,
              tbl[k].ev, tbl[k].ee, tbl[k].epn, tbl[k].ep, tbl[k].ecnt);
      if (!tbl[k].fstop) begin
        line_a(1'b0, 3);
        line_a(1'b1, 1);
      end
    end

    // Mid-frame reset after the 4th bit: aborted frame leaves no trace.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) sin_a = (i == 1 || i == 3) ? 1'b1 : 1'b0;
      @(posedge clk) #1;
    end
    @(negedge clk) begin rst_na = 1'b0; sin_a = 1'b1; end
    @(posedge clk) #1;
    chk("mrst_valid", valid_a, 0);
    chk("mrst_error", error_a, 0);
    chk("mrst_pn", pn_a, 0);
    chk("mrst_p", p_a, 0);
    chk("mrst_chv", chv_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_cnt", cnt_a, 0);
    @(negedge clk) rst_na = 1'b1;
    @(posedge clk) #1;
    line_a(1'b1, 3);
    m_pn = 2'd0; m_p = 4'h0; m_cnt = 0;
    model_frame_a(2'd1, 4'h3, 1'b1, 1'b1);

    // Randomized frames against the model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] rpn;
      logic [3:0] rd;
      logic       rpar, rstop;
      int         kind;
      rpn  = 2'($urandom_range(0, 3));
      rd   = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      rpar = ^{rpn, rd};
      rstop = 1'b1;
      if (kind == 2) rpar = ~rpar;
      if (kind == 3) begin
        rstop = 1'b0;
        rpar  = 1'($urandom_range(0, 1));
      end
      model_frame_a(rpn, rd, rpar, rstop);
      if ($urandom_range(0, 2) == 0) line_a(1'b1, $urandom_range(1, 3));
    end

    // Wide configuration, then error-counter saturation.
    frame_b(3'd5, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd5, 8'hA5, 8'd0);
    @(negedge clk) sin_b = 1'b1;
    @(posedge clk) #1;
    chk("b_pulse_len", valid_b, 0);
    for (int k = 1; k <= 260; k++) begin
      frame_b(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'b0,
              1'b0, 1'b1, 3'd5, 8'hA5, (k > 255) ? 8'hFF : 8'(k));
      @(negedge clk) sin_b = 1'b1;
      @(posedge clk) #1;
    end
    chk("b_sat_final", cnt_b, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
